// File: rtl/bus_cycle_pkg.sv
// rtl/bus_cycle_pkg.sv - shared types and constants for the local-bus cycle sequencer
package bus_cycle_pkg;

   typedef enum logic [1:0] {
      TGT_RAM,
      TGT_ROM,
      TGT_CPLD,
      TGT_ATA
   } target_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PEND,
      ST_ACT,
      ST_GAP,
      ST_NULL
   } state_t;

   // Byte-enable patterns (active low): OR-ing a mask forces one half off.
   localparam logic [3:0] BE_NONE    = 4'b1111;
   localparam logic [3:0] BE_MASK_LO = 4'b0011;
   localparam logic [3:0] BE_MASK_HI = 4'b1100;

   function automatic logic is_16bit(input target_t t);
      return (t == TGT_ROM) || (t == TGT_ATA);
   endfunction

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - combinational region decode and half-word need from byte enables
module bus_decode
   import bus_cycle_pkg::*;
(
   input  logic       mio,
   input  logic       a31,
   input  logic       a13,
   input  logic [3:0] be,
   output logic [1:0] tgt,
   output logic       lo_need,
   output logic       hi_need
);

   always_comb begin
      tgt = TGT_RAM;
      if (mio) begin
         tgt = a31 ? TGT_ROM : TGT_RAM;
      end else begin
         tgt = a13 ? TGT_CPLD : TGT_ATA;
      end
   end

   assign lo_need = ((be | BE_MASK_HI) != BE_NONE);
   assign hi_need = ((be | BE_MASK_LO) != BE_NONE);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 386 local-bus cycle sequencer with per-region wait states
module bus_cycle_ctrl
   import bus_cycle_pkg::*;
#(
   parameter int WS_RAM  = 0,
   parameter int WS_ROM  = 3,
   parameter int WS_CPLD = 1,
   parameter int WS_ATA  = 5,
   parameter int ATA_REC = 4,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       RESETb,
   input  logic       ADSb,
   input  logic       MIO,
   input  logic       WR,
   input  logic       A31,
   input  logic       A13,
   input  logic       A10,
   input  logic [3:0] BEb,
   output logic       READYb,
   output logic       RAMCEb,
   output logic       ROMCSb,
   output logic       CPLDCSb,
   output logic       ATACS0b,
   output logic       ATACS1b,
   output logic       OEb,
   output logic       WEb,
   output logic       A1,
   output logic       BUSY
);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rec;
   target_t          tgt_q;
   logic             wr_q, a10_q, lo_q, hi_q, upper_q;

   logic [1:0]       dec_tgt_raw;
   target_t          dec_tgt;
   logic             dec_lo, dec_hi;

   target_t          sel_tgt;
   logic             sel_wr, sel_a10, sel_lo, sel_hi, sel_is16, sel_two;
   logic [CNT_W-1:0] ws_sel, ws_q;
   logic             two_q, last_q;
   logic             null_go, start_go, fin;

   bus_decode u_decode (
      .mio     (MIO),
      .a31     (A31),
      .a13     (A13),
      .be      (BEb),
      .tgt     (dec_tgt_raw),
      .lo_need (dec_lo),
      .hi_need (dec_hi)
   );

   assign dec_tgt = target_t'(dec_tgt_raw);

   function automatic logic [CNT_W-1:0] ws_of(input target_t t);
      case (t)
         TGT_RAM:  return CNT_W'(WS_RAM);
         TGT_ROM:  return CNT_W'(WS_ROM);
         TGT_CPLD: return CNT_W'(WS_CPLD);
         default:  return CNT_W'(WS_ATA);
      endcase
   endfunction

   // In IDLE an access starts from the live bus; from PEND it starts from the latched copy.
   assign sel_tgt  = (state == ST_IDLE) ? dec_tgt : tgt_q;
   assign sel_wr   = (state == ST_IDLE) ? WR      : wr_q;
   assign sel_a10  = (state == ST_IDLE) ? A10     : a10_q;
   assign sel_lo   = (state == ST_IDLE) ? dec_lo  : lo_q;
   assign sel_hi   = (state == ST_IDLE) ? dec_hi  : hi_q;
   assign sel_is16 = is_16bit(sel_tgt);
   assign sel_two  = sel_is16 && sel_lo && sel_hi;
   assign ws_sel   = ws_of(sel_tgt);

   assign ws_q     = ws_of(tgt_q);
   assign two_q    = is_16bit(tgt_q) && lo_q && hi_q;
   assign last_q   = !(two_q && !upper_q);

   assign null_go  = (state == ST_IDLE) && !ADSb && (BEb == BE_NONE);
   assign start_go = ((state == ST_IDLE) && !ADSb && (BEb != BE_NONE) &&
                      !((dec_tgt == TGT_ATA) && (rec != '0))) ||
                     ((state == ST_PEND) && (rec == '0));

   // fin: the next cycle is the final ACT cycle, so READYb is registered low for it.
   assign fin = (start_go && (ws_sel == '0) && !sel_two) ||
                ((state == ST_ACT) && (cnt == CNT_W'(1)) && last_q) ||
                ((state == ST_GAP) && (ws_q == '0));

   always_ff @(posedge clk or negedge RESETb) begin
      if (!RESETb) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rec     <= '0;
         tgt_q   <= TGT_RAM;
         wr_q    <= 1'b0;
         a10_q   <= 1'b0;
         lo_q    <= 1'b0;
         hi_q    <= 1'b0;
         upper_q <= 1'b0;
         READYb  <= 1'b1;
         RAMCEb  <= 1'b1;
         ROMCSb  <= 1'b1;
         CPLDCSb <= 1'b1;
         ATACS0b <= 1'b1;
         ATACS1b <= 1'b1;
         OEb     <= 1'b1;
         WEb     <= 1'b1;
         A1      <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         READYb <= !(fin || null_go);

         if (fin && (sel_tgt == TGT_ATA)) begin
            rec <= CNT_W'(ATA_REC);
         end else if (rec != '0) begin
            rec <= rec - CNT_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (!ADSb) begin
                  tgt_q <= dec_tgt;
                  wr_q  <= WR;
                  a10_q <= A10;
                  lo_q  <= dec_lo;
                  hi_q  <= dec_hi;
                  BUSY  <= 1'b1;
                  if (BEb == BE_NONE) begin
                     state <= ST_NULL;
                  end else if ((dec_tgt == TGT_ATA) && (rec != '0)) begin
                     state <= ST_PEND;
                  end
               end
            end
            ST_PEND: begin
            end
            ST_ACT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (!last_q) begin
                  state   <= ST_GAP;
                  OEb     <= 1'b1;
                  WEb     <= 1'b1;
                  A1      <= 1'b1;
                  upper_q <= 1'b1;
               end else begin
                  state   <= ST_IDLE;
                  RAMCEb  <= 1'b1;
                  ROMCSb  <= 1'b1;
                  CPLDCSb <= 1'b1;
                  ATACS0b <= 1'b1;
                  ATACS1b <= 1'b1;
                  OEb     <= 1'b1;
                  WEb     <= 1'b1;
                  A1      <= 1'b0;
                  BUSY    <= 1'b0;
               end
            end
            ST_GAP: begin
               state <= ST_ACT;
               cnt   <= ws_q;
               OEb   <= wr_q;
               WEb   <= !wr_q;
            end
            ST_NULL: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (start_go) begin
            state   <= ST_ACT;
            cnt     <= ws_sel;
            RAMCEb  <= !(sel_tgt == TGT_RAM);
            ROMCSb  <= !(sel_tgt == TGT_ROM);
            CPLDCSb <= !(sel_tgt == TGT_CPLD);
            ATACS0b <= !((sel_tgt == TGT_ATA) && !sel_a10);
            ATACS1b <= !((sel_tgt == TGT_ATA) && sel_a10);
            OEb     <= sel_wr;
            WEb     <= !sel_wr;
            A1      <= sel_is16 && !sel_lo;
            upper_q <= sel_is16 && !sel_lo;
         end
      end
   end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - directed scoreboard bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

   logic       clk = 1'b0;
   logic       RESETb, ADSb, MIO, WR, A31, A13, A10;
   logic [3:0] BEb;
   logic       READYb, RAMCEb, ROMCSb, CPLDCSb, ATACS0b, ATACS1b, OEb, WEb, A1, BUSY;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [4:0] mask;
      int         cs;
      int         oe;
      int         we;
      int         a1;
      int         first;
      int         lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bus_cycle_ctrl dut (
      .clk     (clk),
      .RESETb  (RESETb),
      .ADSb    (ADSb),
      .MIO     (MIO),
      .WR      (WR),
      .A31     (A31),
      .A13     (A13),
      .A10     (A10),
      .BEb     (BEb),
      .READYb  (READYb),
      .RAMCEb  (RAMCEb),
      .ROMCSb  (ROMCSb),
      .CPLDCSb (CPLDCSb),
      .ATACS0b (ATACS0b),
      .ATACS1b (ATACS1b),
      .OEb     (OEb),
      .WEb     (WEb),
      .A1      (A1),
      .BUSY    (BUSY)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // bit 0 RAM, 1 ROM, 2 CPLD, 3 ATA CS0, 4 ATA CS1
   function automatic logic [4:0] cs_vec();
      return {~ATACS1b, ~ATACS0b, ~CPLDCSb, ~ROMCSb, ~RAMCEb};
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, ".idle_cs"}, int'(cs_vec()), 0);
      chk({tag, ".idle_oe"}, int'(OEb), 1);
      chk({tag, ".idle_we"}, int'(WEb), 1);
      chk({tag, ".idle_ready"}, int'(READYb), 1);
      chk({tag, ".idle_busy"}, int'(BUSY), 0);
   endtask

   // Called at a negedge: ADSb is sampled on the next posedge, t counts cycles after it.
   task automatic run(input string name, input logic mio, input logic wr, input logic a31,
                      input logic a13, input logic a10, input logic [3:0] be,
                      input logic [4:0] mask, input int cs, input int oe, input int we,
                      input int a1, input int first, input int lat);
      exp_t       e;
      exp_t       x;
      int         t, cs_o, oe_o, we_o, a1_o, first_o;
      logic [4:0] mask_o;
      logic       done;
      e = '{name, mask, cs, oe, we, a1, first, lat};
      sb.push_back(e);
      MIO = mio; WR = wr; A31 = a31; A13 = a13; A10 = a10; BEb = be; ADSb = 1'b0;
      t = 0; cs_o = 0; oe_o = 0; we_o = 0; a1_o = 0; first_o = 0; mask_o = '0; done = 1'b0;
      while (!done && t < 80) begin
         @(negedge clk);
         ADSb = 1'b1;
         t++;
         if (cs_vec() != 5'b0) begin
            cs_o++;
            if (first_o == 0) first_o = t;
         end
         mask_o = mask_o | cs_vec();
         if (!OEb) oe_o++;
         if (!WEb) we_o++;
         if (A1) a1_o++;
         if (!READYb) done = 1'b1;
      end
      x = sb.pop_front();
      chk({x.name, ".ready_seen"}, int'(done), 1);
      chk({x.name, ".cs_mask"}, int'(mask_o), int'(x.mask));
      chk({x.name, ".cs_cycles"}, cs_o, x.cs);
      chk({x.name, ".oe_cycles"}, oe_o, x.oe);
      chk({x.name, ".we_cycles"}, we_o, x.we);
      chk({x.name, ".a1_cycles"}, a1_o, x.a1);
      chk({x.name, ".first_cs"}, first_o, x.first);
      chk({x.name, ".latency"}, t, x.lat);
      @(negedge clk);
      check_idle(x.name);
   endtask

   initial begin
      int rdy_lows;
      int cs_lows;
      RESETb = 1'b0; ADSb = 1'b1; MIO = 1'b0; WR = 1'b0;
      A31 = 1'b0; A13 = 1'b0; A10 = 1'b0; BEb = 4'b1111;
      repeat (3) @(negedge clk);
      check_idle("reset");
      chk("reset.a1", int'(A1), 0);
      RESETb = 1'b1;
      @(negedge clk);

      //  name              mio wr a31 a13 a10 be       mask      cs oe we a1 first lat
      run("ram_rd",         1, 0, 0, 0, 0, 4'b0000, 5'b00001,  1, 1, 0, 0, 1,  1);
      run("rom_rd_full",    1, 0, 1, 0, 0, 4'b0000, 5'b00010,  9, 8, 0, 5, 1,  9);
      run("rom_rd_hi",      1, 0, 1, 0, 0, 4'b0011, 5'b00010,  4, 4, 0, 4, 1,  4);
      run("cpld_wr",        0, 1, 0, 1, 0, 4'b0000, 5'b00100,  2, 0, 2, 0, 1,  2);
      run("null_be",        1, 0, 0, 0, 0, 4'b1111, 5'b00000,  0, 0, 0, 0, 0,  1);
      run("ata_wr",         0, 1, 0, 0, 1, 4'b1100, 5'b10000,  6, 0, 6, 0, 1,  6);
      run("ata_rd_b2b",     0, 0, 0, 0, 0, 4'b1100, 5'b01000,  6, 6, 0, 0, 4,  9);
      run("rom_after_ata",  1, 0, 1, 0, 0, 4'b0011, 5'b00010,  4, 4, 0, 4, 1,  4);
      run("ata_rd_split",   0, 0, 0, 0, 1, 4'b0000, 5'b10000, 13,12, 0, 7, 1, 13);
      run("ram_wr_byte",    1, 1, 0, 0, 0, 4'b1110, 5'b00001,  1, 0, 1, 0, 1,  1);
      run("rom_rd_lo",      1, 0, 1, 0, 0, 4'b1100, 5'b00010,  4, 4, 0, 0, 1,  4);

      // Reset pulsed in the middle of a ROM read's first ACT phase.
      MIO = 1'b1; WR = 1'b0; A31 = 1'b1; A13 = 1'b0; A10 = 1'b0; BEb = 4'b0000; ADSb = 1'b0;
      @(negedge clk);
      ADSb = 1'b1;
      @(negedge clk);
      chk("rst_mid.rom_cs_active", int'(ROMCSb), 0);
      chk("rst_mid.busy_active", int'(BUSY), 1);
      #1 RESETb = 1'b0;
      #1;
      check_idle("rst_mid.async");
      @(negedge clk);
      RESETb = 1'b1;
      rdy_lows = 0;
      cs_lows  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!READYb) rdy_lows++;
         if (cs_vec() != 5'b0) cs_lows++;
      end
      chk("rst_mid.no_ready", rdy_lows, 0);
      chk("rst_mid.no_cs", cs_lows, 0);
      check_idle("rst_mid.after");

      run("ram_after_rst",  1, 0, 0, 1, 0, 4'b0000, 5'b00001,  1, 1, 0, 0, 1,  1);

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
